// File: rtl/sload_period_sequencer.sv
// sload_period_sequencer: turns a free-running 4-bit counter with synchronous
// load into a modulo counter running LOAD_VAL..TERM for NPER periods, and
// checks that the returned count follows the expected sequence.
module sload_period_sequencer #(
  parameter logic [3:0]  LOAD_VAL = 4'b1010,
  parameter logic [3:0]  TERM     = 4'b1111,
  parameter int unsigned NPER     = 4
) (
  input  logic       C,
  input  logic       R,
  input  logic       START,
  input  logic       ABORT,
  input  logic [3:0] Q_IN,
  output logic       SLOAD,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] PCOUNT
);

  localparam int unsigned CW = 4;
  localparam int unsigned PW = 8;

  // SLOAD is registered, so the reload is requested one count before TERM.
  localparam logic [CW-1:0] TRIG    = TERM - CW'(1);
  localparam logic [PW-1:0] NPER_M1 = PW'(NPER - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] exp_q;
  logic [CW-1:0] exp_n;
  logic          sload_n;
  logic          busy_n;
  logic          done_n;
  logic          err_n;
  logic [PW-1:0] pcount_n;
  logic          mismatch;
  logic          at_trig;

  assign mismatch = (Q_IN != exp_q);
  assign at_trig  = (Q_IN == TRIG);

  // State and output registers; R restores every register to its idle value.
  always_ff @(posedge C) begin
    if (R) begin
      state  <= S_IDLE;
      exp_q  <= '0;
      SLOAD  <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
      PCOUNT <= '0;
    end else begin
      state  <= state_n;
      exp_q  <= exp_n;
      SLOAD  <= sload_n;
      BUSY   <= busy_n;
      DONE   <= done_n;
      ERR    <= err_n;
      PCOUNT <= pcount_n;
    end
  end

  // Next-state, expected-count tracking, reload trigger and sequence check.
  always_comb begin
    state_n  = state;
    exp_n    = exp_q;
    sload_n  = SLOAD;
    busy_n   = BUSY;
    done_n   = 1'b0;
    err_n    = ERR;
    pcount_n = PCOUNT;

    case (state)
      S_IDLE: begin
        // ABORT has no meaning here, so START always wins.
        sload_n = 1'b0;
        if (START) begin
          state_n  = S_PRIME;
          sload_n  = 1'b1;
          busy_n   = 1'b1;
          pcount_n = '0;
          err_n    = 1'b0;
        end
      end

      S_PRIME: begin
        if (ABORT) begin
          state_n = S_IDLE;
          sload_n = 1'b0;
          busy_n  = 1'b0;
        end else begin
          // Counter takes LOAD_VAL at this edge; start tracking from there.
          state_n = S_RUN;
          sload_n = 1'b0;
          exp_n   = LOAD_VAL;
        end
      end

      S_RUN: begin
        if (ABORT) begin
          state_n = S_IDLE;
          sload_n = 1'b0;
          busy_n  = 1'b0;
        end else begin
          exp_n = SLOAD ? LOAD_VAL : exp_q + CW'(1);
          if (mismatch) begin
            err_n = 1'b1;
          end
          if (at_trig) begin
            sload_n  = 1'b1;
            pcount_n = PCOUNT + PW'(1);
            if (PCOUNT == NPER_M1) begin
              state_n = S_FINISH;
            end
          end else begin
            sload_n = 1'b0;
          end
        end
      end

      S_FINISH: begin
        if (ABORT) begin
          state_n = S_IDLE;
          sload_n = 1'b0;
          busy_n  = 1'b0;
        end else begin
          // Last reload happens at this edge; the run is complete.
          if (mismatch) begin
            err_n = 1'b1;
          end
          state_n = S_IDLE;
          sload_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        sload_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sload_period_sequencer.sv
// Bench for sload_period_sequencer: closes the loop through a behavioural
// load/increment counter and compares every cycle against a timeline model.
`timescale 1ns/1ps
module tb_sload_period_sequencer;

  localparam logic [3:0] LV     = 4'b1010;
  localparam logic [3:0] TERM_A = 4'b1111;
  localparam int         NPER_A = 2;
  localparam logic [3:0] TERM_W = 4'b0001;
  localparam int         NPER_W = 1;
  localparam int         P_A    = ((int'(TERM_A) - int'(LV) + 16) % 16) + 1;
  localparam int         P_W    = ((int'(TERM_W) - int'(LV) + 16) % 16) + 1;

  typedef struct packed {
    logic       sload;
    logic       busy;
    logic       done;
    logic [7:0] pcount;
  } exp_t;

  logic       clk;
  logic       r;
  logic       start;
  logic       abort;
  logic       force_zero;
  logic [3:0] q_cnt = 4'd0;
  logic [3:0] q_in;
  logic       sload, busy, done, err;
  logic [7:0] pcount;

  logic       start_w;
  logic       abort_w;
  logic [3:0] q_cnt_w = 4'd0;
  logic       sload_w, busy_w, done_w, err_w;
  logic [7:0] pcount_w;

  int n_cmp  = 0;
  int n_fail = 0;

  assign q_in = force_zero ? 4'd0 : q_cnt;

  sload_period_sequencer #(.LOAD_VAL(LV), .TERM(TERM_A), .NPER(NPER_A)) dut (
    .C(clk), .R(r), .START(start), .ABORT(abort), .Q_IN(q_in),
    .SLOAD(sload), .BUSY(busy), .DONE(done), .ERR(err), .PCOUNT(pcount)
  );

  sload_period_sequencer #(.LOAD_VAL(LV), .TERM(TERM_W), .NPER(NPER_W)) dut_w (
    .C(clk), .R(r), .START(start_w), .ABORT(abort_w), .Q_IN(q_cnt_w),
    .SLOAD(sload_w), .BUSY(busy_w), .DONE(done_w), .ERR(err_w), .PCOUNT(pcount_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream counters: load LOAD_VAL on SLOAD, otherwise increment.
  always_ff @(posedge clk) q_cnt   <= (sload === 1'b1)   ? LV : q_cnt + 4'd1;
  always_ff @(posedge clk) q_cnt_w <= (sload_w === 1'b1) ? LV : q_cnt_w + 4'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs k edges after the START edge, for period p and n periods.
  function automatic exp_t model(input int k, input int p, input int n, input int abort_at);
    exp_t m;
    m = '0;
    if (abort_at > 0 && k >= abort_at) begin
      m.pcount = 8'((abort_at - 1) / p);
    end else if (k == 0) begin
      m.sload = 1'b1;
      m.busy  = 1'b1;
    end else if (k <= p * n) begin
      m.sload  = (k % p == 0);
      m.busy   = 1'b1;
      m.pcount = 8'(k / p);
    end else begin
      m.pcount = 8'(n);
      m.done   = (k == p * n + 1);
    end
    return m;
  endfunction

  // Expected counter value k edges after START while the run is active.
  function automatic logic [3:0] q_model(input int k, input int p);
    return 4'((int'(LV) + (k - 1) % p) % 16);
  endfunction

  task automatic test_reset();
    logic [3:0] q0;
    r = 1'b1;
    tick();
    tick();
    n_cmp++; if (sload !== 1'b0)   begin n_fail++; $display("FAIL reset_sload got %0b want 0", sload); end
    n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_cmp++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err got %0b want 0", err); end
    n_cmp++; if (pcount !== 8'd0)  begin n_fail++; $display("FAIL reset_pcount got %0d want 0", pcount); end
    n_cmp++; if (busy_w !== 1'b0)  begin n_fail++; $display("FAIL reset_busy_w got %0b want 0", busy_w); end
    r  = 1'b0;
    q0 = q_cnt;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++; if (q_cnt !== 4'(q0 + 4'(i))) begin n_fail++; $display("FAIL idle_count i=%0d got %0h want %0h", i, q_cnt, 4'(q0 + 4'(i))); end
      n_cmp++; if (sload !== 1'b0) begin n_fail++; $display("FAIL idle_sload i=%0d got %0b want 0", i, sload); end
    end
  endtask

  task automatic test_nominal();
    exp_t m;
    repeat (int'($urandom_range(0, 5))) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= P_A * NPER_A + 3; k++) begin
      if (k > 0) tick();
      m = model(k, P_A, NPER_A, 0);
      n_cmp++; if (sload !== m.sload)   begin n_fail++; $display("FAIL nom_sload k=%0d got %0b want %0b", k, sload, m.sload); end
      n_cmp++; if (busy !== m.busy)     begin n_fail++; $display("FAIL nom_busy k=%0d got %0b want %0b", k, busy, m.busy); end
      n_cmp++; if (done !== m.done)     begin n_fail++; $display("FAIL nom_done k=%0d got %0b want %0b", k, done, m.done); end
      n_cmp++; if (pcount !== m.pcount) begin n_fail++; $display("FAIL nom_pcount k=%0d got %0d want %0d", k, pcount, m.pcount); end
      n_cmp++; if (err !== 1'b0)        begin n_fail++; $display("FAIL nom_err k=%0d got %0b want 0", k, err); end
      if (k >= 1 && k <= P_A * NPER_A + 1) begin
        n_cmp++; if (q_cnt !== q_model(k, P_A)) begin n_fail++; $display("FAIL nom_q k=%0d got %0h want %0h", k, q_cnt, q_model(k, P_A)); end
      end
    end
  endtask

  task automatic test_abort(input int fixed_at);
    exp_t m;
    int   a;
    a = (fixed_at > 0) ? fixed_at : int'($urandom_range(1, P_A * NPER_A + 1));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= P_A * NPER_A + 3; k++) begin
      if (k > 0) begin
        abort = (k == a);
        tick();
      end
      m = model(k, P_A, NPER_A, a);
      n_cmp++; if (sload !== m.sload)   begin n_fail++; $display("FAIL abort_sload a=%0d k=%0d got %0b want %0b", a, k, sload, m.sload); end
      n_cmp++; if (busy !== m.busy)     begin n_fail++; $display("FAIL abort_busy a=%0d k=%0d got %0b want %0b", a, k, busy, m.busy); end
      n_cmp++; if (done !== m.done)     begin n_fail++; $display("FAIL abort_done a=%0d k=%0d got %0b want %0b", a, k, done, m.done); end
      n_cmp++; if (pcount !== m.pcount) begin n_fail++; $display("FAIL abort_pcount a=%0d k=%0d got %0d want %0d", a, k, pcount, m.pcount); end
      n_cmp++; if (err !== 1'b0)        begin n_fail++; $display("FAIL abort_err a=%0d k=%0d got %0b want 0", a, k, err); end
    end
    abort = 1'b0;
  endtask

  task automatic test_mismatch();
    exp_t m;
    int   f;
    logic e;
    // Force only while the true count is LOAD_VAL..LOAD_VAL+3, clear of the trigger.
    f = 2 + int'($urandom_range(0, NPER_A - 1)) * P_A + int'($urandom_range(0, 3));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= P_A * NPER_A + 3; k++) begin
      if (k > 0) begin
        force_zero = (k == f);
        tick();
      end
      m = model(k, P_A, NPER_A, 0);
      e = (k >= f);
      n_cmp++; if (err !== e)           begin n_fail++; $display("FAIL mis_err f=%0d k=%0d got %0b want %0b", f, k, err, e); end
      n_cmp++; if (done !== m.done)     begin n_fail++; $display("FAIL mis_done f=%0d k=%0d got %0b want %0b", f, k, done, m.done); end
      n_cmp++; if (sload !== m.sload)   begin n_fail++; $display("FAIL mis_sload f=%0d k=%0d got %0b want %0b", f, k, sload, m.sload); end
      n_cmp++; if (pcount !== m.pcount) begin n_fail++; $display("FAIL mis_pcount f=%0d k=%0d got %0d want %0d", f, k, pcount, m.pcount); end
    end
    force_zero = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (err !== 1'b0)    begin n_fail++; $display("FAIL mis_clear_err got %0b want 0", err); end
    n_cmp++; if (pcount !== 8'd0) begin n_fail++; $display("FAIL mis_clear_pcount got %0d want 0", pcount); end
    repeat (P_A * NPER_A + 3) tick();
    n_cmp++; if (err !== 1'b0)    begin n_fail++; $display("FAIL mis_clean_run_err got %0b want 0", err); end
  endtask

  task automatic test_simultaneous();
    exp_t m;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k <= P_A * NPER_A + 3; k++) begin
      if (k > 0) begin
        start = (k <= P_A * NPER_A + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      m = model(k, P_A, NPER_A, 0);
      n_cmp++; if (sload !== m.sload)   begin n_fail++; $display("FAIL sim_sload k=%0d got %0b want %0b", k, sload, m.sload); end
      n_cmp++; if (busy !== m.busy)     begin n_fail++; $display("FAIL sim_busy k=%0d got %0b want %0b", k, busy, m.busy); end
      n_cmp++; if (done !== m.done)     begin n_fail++; $display("FAIL sim_done k=%0d got %0b want %0b", k, done, m.done); end
      n_cmp++; if (pcount !== m.pcount) begin n_fail++; $display("FAIL sim_pcount k=%0d got %0d want %0d", k, pcount, m.pcount); end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int rk;
    rk = int'($urandom_range(1, P_A * NPER_A));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (rk - 1) tick();
    r = 1'b1;
    tick();
    r = 1'b0;
    n_cmp++; if (sload !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_sload rk=%0d got %0b want 0", rk, sload); end
    n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_busy rk=%0d got %0b want 0", rk, busy); end
    n_cmp++; if (pcount !== 8'd0) begin n_fail++; $display("FAIL rst_mid_pcount rk=%0d got %0d want 0", rk, pcount); end
    repeat (P_A + 2) begin
      tick();
      n_cmp++; if (busy !== 1'b0 || sload !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_idle got busy=%0b sload=%0b done=%0b want 0/0/0", busy, sload, done);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t m;
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    for (int k = 0; k <= P_W * NPER_W + 3; k++) begin
      if (k > 0) tick();
      m = model(k, P_W, NPER_W, 0);
      n_cmp++; if (sload_w !== m.sload)   begin n_fail++; $display("FAIL wrap_sload k=%0d got %0b want %0b", k, sload_w, m.sload); end
      n_cmp++; if (busy_w !== m.busy)     begin n_fail++; $display("FAIL wrap_busy k=%0d got %0b want %0b", k, busy_w, m.busy); end
      n_cmp++; if (done_w !== m.done)     begin n_fail++; $display("FAIL wrap_done k=%0d got %0b want %0b", k, done_w, m.done); end
      n_cmp++; if (pcount_w !== m.pcount) begin n_fail++; $display("FAIL wrap_pcount k=%0d got %0d want %0d", k, pcount_w, m.pcount); end
      n_cmp++; if (err_w !== 1'b0)        begin n_fail++; $display("FAIL wrap_err k=%0d got %0b want 0", k, err_w); end
      if (k >= 1 && k <= P_W * NPER_W + 1) begin
        n_cmp++; if (q_cnt_w !== q_model(k, P_W)) begin n_fail++; $display("FAIL wrap_q k=%0d got %0h want %0h", k, q_cnt_w, q_model(k, P_W)); end
      end
    end
  endtask

  initial begin
    r          = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    force_zero = 1'b0;
    start_w    = 1'b0;
    abort_w    = 1'b0;
    test_reset();
    test_nominal();
    test_nominal();
    test_abort(4);
    repeat (4) test_abort(0);
    test_mismatch();
    test_simultaneous();
    test_reset_midrun();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

endmodule
